fxp_mult_pipe: RTL and testbench

Parametrised, pipelined signed fixed-point multiplier for the ALU datapath. It is the successor of the combinational Q6.10 multiply.
- Generalises operand width and fraction bits.
- Adds a per-transaction rounding mode (round-to-nearest-even or truncate).
- Registers the result through a two-stage elastic pipeline with valid/ready backpressure.
- Saturates out-of-range results to the signed limits of the output format.

---
 rtl/fxp_mult_pipe_if.sv | 28 ++
 rtl/fxp_mult_pipe.sv | 147 ++++++++++++++
 tb/tb_fxp_mult_pipe.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fxp_mult_pipe_if.sv
// Handshake and data bundle for fxp_mult_pipe: operand side, result side and status.
// The slave modport is the multiplier's view; the master modport is the driver's view.
interface fxp_mult_pipe_if #(
  parameter int DATA_W = 16
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data_1;
  logic [DATA_W-1:0] i_data_2;
  logic              i_rnd_mode;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_sat;
  logic              i_clr;
  logic              o_sat_sticky;
  logic [15:0]       o_sat_cnt;

  modport slave (
    input  i_valid, i_data_1, i_data_2, i_rnd_mode, i_ready, i_clr,
    output o_ready, o_valid, o_data, o_sat, o_sat_sticky, o_sat_cnt
  );

  modport master (
    output i_valid, i_data_1, i_data_2, i_rnd_mode, i_ready, i_clr,
    input  o_ready, o_valid, o_data, o_sat, o_sat_sticky, o_sat_cnt
  );
endinterface

// File: rtl/fxp_mult_pipe.sv
// Signed fixed-point multiply with RNE/truncate rounding and saturation; status counters under FXP_MULT_STATUS_EN.
// Latency 2 cycles (S1 product register, S2 rounded/saturated result), 1 result per cycle.
// Backpressure: two-stage elastic pipeline, o_ready = ~s1 | ~s2 | i_ready, results held stable while stalled.
module fxp_mult_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  fxp_mult_pipe_if.slave    bus
);

  localparam int PW = 2 * DATA_W;
  localparam int KW = PW - FRAC_W + 1;

  logic              s1_vld_q, s1_vld_d;
  logic [PW-1:0]     s1_prod_q, s1_prod_d;
  logic              s1_mode_q, s1_mode_d;
  logic              s2_vld_q, s2_vld_d;
  logic [DATA_W-1:0] s2_dat_q, s2_dat_d;
  logic              s2_sat_q, s2_sat_d;

  logic              in_rdy;
  logic              in_xfer;
  logic              out_xfer;
  logic              s2_load;
  logic [PW-1:0]     prod;
  logic [KW-1:0]     k_ext;
  logic [KW-1:0]     rnd;
  logic [KW-DATA_W:0] rnd_hi;
  logic              sticky;
  logic              inc;
  logic              ovf;
  logic [DATA_W-1:0] sat_lim;

  assign out_xfer = s2_vld_q & bus.i_ready;
  assign s2_load  = s1_vld_q & (~s2_vld_q | out_xfer);
  assign in_rdy   = ~s1_vld_q | ~s2_vld_q | bus.i_ready;
  assign in_xfer  = bus.i_valid & in_rdy;

  always_comb begin
    prod = {{DATA_W{bus.i_data_1[DATA_W-1]}}, bus.i_data_1} *
           {{DATA_W{bus.i_data_2[DATA_W-1]}}, bus.i_data_2};
  end

  // Rounding uses the product held in S1; K is the floor of P / 2^FRAC_W.
  always_comb begin
    k_ext  = {s1_prod_q[PW-1], s1_prod_q[PW-1:FRAC_W]};
    sticky = 1'b0;
    for (int i = 0; i < FRAC_W - 1; i++) begin
      sticky = sticky | s1_prod_q[i];
    end
    inc     = ~s1_mode_q & s1_prod_q[FRAC_W-1] & (sticky | s1_prod_q[FRAC_W]);
    rnd     = k_ext + {{(KW-1){1'b0}}, inc};
    rnd_hi  = rnd[KW-1:DATA_W-1];
    ovf     = ~((&rnd_hi) | ~(|rnd_hi));
    sat_lim = rnd[KW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_prod_d = s1_prod_q;
    s1_mode_d = s1_mode_q;
    if (in_xfer) begin
      s1_vld_d  = 1'b1;
      s1_prod_d = prod;
      s1_mode_d = bus.i_rnd_mode;
    end else if (s2_load) begin
      s1_vld_d  = 1'b0;
    end
  end

  always_comb begin
    s2_vld_d = s2_vld_q;
    s2_dat_d = s2_dat_q;
    s2_sat_d = s2_sat_q;
    if (s2_load) begin
      s2_vld_d = 1'b1;
      s2_dat_d = ovf ? sat_lim : rnd[DATA_W-1:0];
      s2_sat_d = ovf;
    end else if (out_xfer) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_prod_q <= '0;
      s1_mode_q <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_dat_q  <= '0;
      s2_sat_q  <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_prod_q <= s1_prod_d;
      s1_mode_q <= s1_mode_d;
      s2_vld_q  <= s2_vld_d;
      s2_dat_q  <= s2_dat_d;
      s2_sat_q  <= s2_sat_d;
    end
  end

  assign bus.o_ready = in_rdy;
  assign bus.o_valid = s2_vld_q;
  assign bus.o_data  = s2_dat_q;
  assign bus.o_sat   = s2_sat_q;

`ifdef FXP_MULT_STATUS_EN
  logic        sat_sticky_q, sat_sticky_d;
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Clear has priority over a saturation event in the same cycle.
  always_comb begin
    sat_sticky_d = sat_sticky_q;
    sat_cnt_d    = sat_cnt_q;
    if (bus.i_clr) begin
      sat_sticky_d = 1'b0;
      sat_cnt_d    = '0;
    end else if (out_xfer && s2_sat_q) begin
      sat_sticky_d = 1'b1;
      if (sat_cnt_q != 16'hFFFF) begin
        sat_cnt_d = sat_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sat_sticky_q <= 1'b0;
      sat_cnt_q    <= '0;
    end else begin
      sat_sticky_q <= sat_sticky_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  assign bus.o_sat_sticky = sat_sticky_q;
  assign bus.o_sat_cnt    = sat_cnt_q;
`else
  logic unused_clr;
  assign unused_clr       = bus.i_clr;
  assign bus.o_sat_sticky = 1'b0;
  assign bus.o_sat_cnt    = '0;
`endif

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Scoreboard bench for fxp_mult_pipe: expected {o_sat,o_data} queued at input transfer, compared at output transfer.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_fxp_mult_pipe;

  localparam int DW = 16;
  localparam int FW = 10;

  logic i_clk;
  logic i_rst_n;
  int   errors;
  int   checks;
  logic [DW:0] exp_q[$];

  fxp_mult_pipe_if #(.DATA_W(DW)) bus();

  fxp_mult_pipe #(.DATA_W(DW), .FRAC_W(FW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

`ifdef FXP_MULT_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  // Reference: exact product, floor, then tie-to-even on the discarded remainder.
  function automatic logic [DW:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
    longint p, k, rem, half, maxv, minv;
    p    = longint'($signed(a)) * longint'($signed(b));
    k    = p >>> FW;
    rem  = p - (k <<< FW);
    half = longint'(1) <<< (FW - 1);
    if (!m && ((rem > half) || ((rem == half) && k[0]))) k = k + 1;
    maxv = (longint'(1) <<< (DW - 1)) - 1;
    minv = -(longint'(1) <<< (DW - 1));
    if (k > maxv) return {1'b1, 1'b0, {(DW-1){1'b1}}};
    if (k < minv) return {1'b1, 1'b1, {(DW-1){1'b0}}};
    return {1'b0, k[DW-1:0]};
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic monitor();
    logic [DW:0] e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && bus.o_valid && bus.i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got=%h sat=%b required=no output", bus.o_data, bus.o_sat);
        end else begin
          e = exp_q.pop_front();
          if ({bus.o_sat, bus.o_data} !== e) begin
            errors++;
            $display("FAIL out_data got sat=%b data=%h required sat=%b data=%h",
                     bus.o_sat, bus.o_data, e[DW], e[DW-1:0]);
          end
        end
      end
    end
  endtask

  // Presents one operand pair until accepted; leaves i_valid high for back-to-back calls.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
    bit ok;
    ok = 1'b0;
    bus.i_valid    = 1'b1;
    bus.i_data_1   = a;
    bus.i_data_2   = b;
    bus.i_rnd_mode = m;
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      if (bus.o_ready) begin
        exp_q.push_back(model(a, b, m));
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL send_timeout a=%h b=%h never accepted", a, b);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic check_latency(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic m);
    bus.i_valid    = 1'b1;
    bus.i_data_1   = a;
    bus.i_data_2   = b;
    bus.i_rnd_mode = m;
    @(negedge i_clk);
    checks++;
    if (bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL lat_ready got=%b required=1", bus.o_ready);
    end else begin
      exp_q.push_back(model(a, b, m));
    end
    tick();
    bus.i_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_early o_valid got=%b required=0 after 1 edge", bus.o_valid);
    end
    tick();
    @(negedge i_clk);
    checks++;
    if (bus.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL lat_on_time o_valid got=%b required=1 after 2 edges", bus.o_valid);
    end
    tick();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) tick();
    @(negedge i_clk);
    checks++;
    if ({bus.o_valid, bus.o_data, bus.o_sat, bus.o_sat_sticky, bus.o_sat_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b data=%h sat=%b sticky=%b cnt=%h required all 0",
               bus.o_valid, bus.o_data, bus.o_sat, bus.o_sat_sticky, bus.o_sat_cnt);
    end
    tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b valid=%b required ready=1 valid=0", bus.o_ready, bus.o_valid);
    end
    tick();
  endtask

  task automatic test_basic();
    check_latency(16'h0600, 16'h0800, 1'b0);
    checks++;
    if (model(16'h0600, 16'h0800, 1'b0) !== 17'h00C00) begin
      errors++;
      $display("FAIL basic_model got=%h required=00c00", model(16'h0600, 16'h0800, 1'b0));
    end
  endtask

  task automatic test_rounding();
    send(16'h0001, 16'h0200, 1'b0);
    send(16'h0001, 16'h0600, 1'b0);
    send(16'h0001, 16'h0600, 1'b1);
    send(16'hFFFF, 16'h0200, 1'b0);
    send(16'hFFFF, 16'h0600, 1'b1);
    send(16'h0003, 16'h0155, 1'b0);
    bus.i_valid = 1'b0;
    drain();
  endtask

  task automatic test_saturation();
    send(16'h7FFF, 16'h7FFF, 1'b0);
    send(16'h8000, 16'h7FFF, 1'b0);
    send(16'h8000, 16'h8000, 1'b0);
    bus.i_valid = 1'b0;
    drain();
    @(negedge i_clk);
    checks++;
    if (bus.o_sat_cnt !== (STATUS ? 16'd3 : 16'd0) || bus.o_sat_sticky !== STATUS) begin
      errors++;
      $display("FAIL sat_status got cnt=%0d sticky=%b required cnt=%0d sticky=%b",
               bus.o_sat_cnt, bus.o_sat_sticky, STATUS ? 3 : 0, STATUS);
    end
    tick();
  endtask

  task automatic test_capacity();
    int acc;
    acc = 0;
    bus.i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.i_valid    = 1'b1;
      bus.i_data_1   = 16'h0400 + 16'(acc);
      bus.i_data_2   = 16'h0C00;
      bus.i_rnd_mode = 1'b0;
      @(negedge i_clk);
      if (bus.o_ready) begin
        exp_q.push_back(model(16'h0400 + 16'(acc), 16'h0C00, 1'b0));
        acc++;
      end
      tick();
    end
    bus.i_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if (acc != 2 || bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL capacity accepted=%0d ready=%b required accepted=2 ready=0", acc, bus.o_ready);
    end
    tick();
    bus.i_ready = 1'b1;
    drain();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] va[6];
    logic [DW-1:0] vb[6];
    logic [DW-1:0] held;
    int idx;
    va = '{16'h0600, 16'hFA00, 16'h7FFF, 16'h0123, 16'h8000, 16'h0001};
    vb = '{16'h0800, 16'h0300, 16'h0400, 16'hFEDC, 16'h0401, 16'h0600};
    idx  = 0;
    held = '0;
    for (int c = 0; c < 40; c++) begin
      bus.i_ready = !(c >= 3 && c <= 7);
      if (idx < 6) begin
        bus.i_valid    = 1'b1;
        bus.i_data_1   = va[idx];
        bus.i_data_2   = vb[idx];
        bus.i_rnd_mode = 1'b0;
      end else begin
        bus.i_valid = 1'b0;
      end
      @(negedge i_clk);
      if (c == 3) held = bus.o_data;
      if (c >= 4 && c <= 7) begin
        checks++;
        if (bus.o_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_ready cycle=%0d got=%b required=0", c, bus.o_ready);
        end
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== held) begin
          errors++;
          $display("FAIL bp_stable cycle=%0d got valid=%b data=%h required valid=1 data=%h",
                   c, bus.o_valid, bus.o_data, held);
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back(model(va[idx], vb[idx], 1'b0));
        idx++;
      end
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    checks++;
    if (idx != 6) begin
      errors++;
      $display("FAIL bp_sent got=%0d required=6", idx);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b0;
    send(16'h0600, 16'h0800, 1'b0);
    send(16'h7FFF, 16'h7FFF, 1'b0);
    bus.i_valid = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_full got valid=%b ready=%b required valid=1 ready=0", bus.o_valid, bus.o_ready);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async got valid=%b required=0", bus.o_valid);
    end
    exp_q.delete();
    repeat (2) tick();
    i_rst_n = 1'b1;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_stale cycle=%0d got valid=%b ready=%b required valid=0 ready=1",
                 c, bus.o_valid, bus.o_ready);
      end
      tick();
    end
    check_latency(16'h0001, 16'h0600, 1'b0);
  endtask

  task automatic test_back_to_back();
    int sent;
    bit stall_free;
    logic [DW-1:0] a, b;
    logic m;
    stall_free = 1'b1;
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      m = 1'($urandom);
      bus.i_valid = 1'b1; bus.i_data_1 = a; bus.i_data_2 = b; bus.i_rnd_mode = m;
      @(negedge i_clk);
      if (!bus.o_ready) stall_free = 1'b0;
      else exp_q.push_back(model(a, b, m));
      tick();
    end
    checks++;
    if (!stall_free) begin
      errors++;
      $display("FAIL stream_bubble o_ready dropped with i_ready=1, required always 1");
    end
    for (int c = 0; c < 600 && sent < 60; c++) begin
      bus.i_ready = ($urandom_range(0, 3) != 0);
      a = 16'($urandom >> (4 * $urandom_range(0, 3)));
      b = 16'($urandom >> (4 * $urandom_range(0, 3)));
      m = 1'($urandom);
      bus.i_valid = 1'b1; bus.i_data_1 = a; bus.i_data_2 = b; bus.i_rnd_mode = m;
      @(negedge i_clk);
      if (bus.o_ready) begin
        exp_q.push_back(model(a, b, m));
        sent++;
      end
      tick();
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    checks++;
    if (sent != 60) begin
      errors++;
      $display("FAIL random_sent got=%0d required=60", sent);
    end
    drain();
  endtask

  task automatic test_status_clear();
    bus.i_ready = 1'b0;
    send(16'h7FFF, 16'h7FFF, 1'b0);
    bus.i_valid = 1'b0;
    tick();
    bus.i_clr   = 1'b1;
    bus.i_ready = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_sat !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup got valid=%b sat=%b required 1 1", bus.o_valid, bus.o_sat);
    end
    tick();
    bus.i_clr = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_sat_cnt !== 16'd0 || bus.o_sat_sticky !== 1'b0) begin
      errors++;
      $display("FAIL clr_wins got cnt=%0d sticky=%b required cnt=0 sticky=0", bus.o_sat_cnt, bus.o_sat_sticky);
    end
    tick();
    send(16'h8000, 16'h7FFF, 1'b1);
    bus.i_valid = 1'b0;
    drain();
    @(negedge i_clk);
    checks++;
    if (bus.o_sat_cnt !== (STATUS ? 16'd1 : 16'd0) || bus.o_sat_sticky !== STATUS) begin
      errors++;
      $display("FAIL clr_recount got cnt=%0d sticky=%b required cnt=%0d sticky=%b",
               bus.o_sat_cnt, bus.o_sat_sticky, STATUS ? 1 : 0, STATUS);
    end
    tick();
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    i_rst_n        = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_data_1   = '0;
    bus.i_data_2   = '0;
    bus.i_rnd_mode = 1'b0;
    bus.i_ready    = 1'b1;
    bus.i_clr      = 1'b0;
    fork
      monitor();
      begin
        #400000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_capacity();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_status_clear();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
